uart_tx: RTL
============

// Module: uart_tx
//
// PURPOSE
//   Transmit half of UART0 (base UART0_BASE_ADDR). Buffers bytes written by the
//   UART0 register interface in a FIFO and serialises them as 8N1 frames, LSB
//   first, at DEFAULT_UART_BAUD. Raises a one-cycle pulse on tx_int when the
//   transmitter drains; the pulse feeds the UART0TX bit (trap code 17) of the
//   interrupt pending CSR.
//
// PARAMETERS
//   CLK_FREQ    lexington::DEFAULT_CLK_FREQ (10_000_000)  core clock in Hz
//   BAUD        lexington::DEFAULT_UART_BAUD (9600)       line rate in bit/s
//   FIFO_DEPTH  lexington::DEFAULT_UART_FIFO_DEPTH (8)    TX FIFO entries; 0 invalid (elaboration $error)
//   Derived:    DIVISOR = CLK_FREQ/BAUD (integer truncation; 1041 at defaults; must be >= 2)
//
// PORTS
//   clk      in   1                        core clock, all logic on rising edge
//   rst      in   1                        asynchronous, active-high reset
//   wr_en    in   1                        push wr_data into FIFO this cycle
//   wr_data  in   8                        byte to transmit
//   full     out  1                        FIFO holds FIFO_DEPTH bytes
//   empty    out  1                        FIFO holds 0 bytes
//   count    out  $clog2(FIFO_DEPTH+1)     bytes currently in FIFO (excludes byte in shifter)
//   busy     out  1                        shifter in START/DATA/STOP
//   tx       out  1                        serial line, idle high
//   tx_int   out  1                        1-cycle pulse: frame done, FIFO empty
//
// BEHAVIOUR
//   Reset (async assert, sync release): tx=1, busy=0, full=0, empty=1, count=0,
//     tx_int=0, FSM=IDLE, FIFO pointers 0, baud counter 0. Reset mid-frame
//     aborts the frame; tx returns high immediately; buffered bytes discarded.
//   All outputs registered.
//   FIFO: circular buffer, pointers wrap at FIFO_DEPTH (not power-of-2 required).
//     - wr_en while full (registered flag at cycle start): byte dropped, no state
//       change; this holds even if a pop occurs in the same cycle.
//     - simultaneous accepted push and pop: count unchanged.
//   Baud counter: counts 0..DIVISOR-1; each FSM bit state lasts exactly DIVISOR
//     cycles; counter cleared on every state entry.
//   FSM:
//     IDLE  : tx=1. If !empty: pop head into shift reg, ->START. Else stay.
//     START : tx=0 for DIVISOR cycles, ->DATA with bit index 0.
//     DATA  : tx=shift[0] for DIVISOR cycles, shift right; after bit 7 ->STOP.
//     STOP  : tx=1 for DIVISOR cycles; at end: if !empty pop and ->START
//             directly (no idle cycle between frames); else ->IDLE and pulse
//             tx_int for exactly one cycle.
//   Latency: wr_en at edge n into empty idle block -> empty=0 after n,
//     pop and tx=0 after edge n+1. Frame = 10*DIVISOR cycles.
//   busy=1 from START entry until IDLE re-entry; tx_int coincides with busy falling.
//
// TESTING (CLK_FREQ=1000, BAUD=100 -> DIVISOR=10, FIFO_DEPTH=8 unless stated)
//   1. Write 0x55 once -> tx: 0 for 10 cycles, then bits 1,0,1,0,1,0,1,0 each 10
//      cycles, stop 1 for 10 cycles; tx_int pulses once, 100 cycles after tx fall.
//   2. Write 0xA3 then 0x0F on consecutive cycles -> two contiguous frames, no
//      extra idle between stop of first and start of second; one tx_int after second.
//   3. wr_en on 10 consecutive cycles into idle block -> 9 accepted (first popped
//      on cycle 2), full=1 after 9th, 10th dropped; 9 frames with correct data out.
//   4. Fill FIFO while full, push on same cycle as STOP-end pop -> push dropped,
//      count goes 8->7.
//   5. Assert rst mid DATA bit 3 -> tx=1, busy=0, empty=1, count=0 without a
//      clock edge; after release, new write 0xFF transmits cleanly.
//   6. Defaults (10 MHz, 9600) -> measured bit period 1041 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// Transmit half of a UART: byte FIFO feeding an 8N1 serialiser, LSB first.
// tx_int pulses for one cycle when the last frame finishes and the FIFO is empty.
module uart_tx #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [7:0]                        wr_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              busy,
    output logic                              tx,
    output logic                              tx_int
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int BAUD_W  = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be at least 1");
    end
    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                tx_int_q, tx_int_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic                bit_end;
    logic                push;
    logic                pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bit_end = (baud_q == BAUD_W'(DIVISOR - 1));
    // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push    = wr_en && !full_q;

    // State register and all datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            tx_int_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            tx_int_q <= tx_int_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Next-state logic; a STOP with more data queued goes straight to START.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_q == 3'd7) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        baud_d = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;

        bit_d = bit_q;
        if (state_q != DATA) begin
            bit_d = '0;
        end else if (bit_end) begin
            bit_d = bit_q + 3'd1;
        end

        shift_d = shift_q;
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
        end else if (state_q == DATA && bit_end) begin
            shift_d = {1'b0, shift_q[7:1]};
        end

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d = (count_d == '0);
    end

    // Outputs are registered from the next state so tx changes on the entry edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d   = (state_d != IDLE);
        tx_int_d = (state_q == STOP) && bit_end && empty_q;
    end

    assign full   = full_q;
    assign empty  = empty_q;
    assign count  = count_q;
    assign busy   = busy_q;
    assign tx     = tx_q;
    assign tx_int = tx_int_q;

endmodule
